// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, single-cycle ALU and an iterative MUL (plus DIV
// when EX_MDIV_EN is defined) that stalls decode and bubbles the memory stage.
module ex_stage #(
    parameter int W         = 32,
    parameter int MC_CYCLES = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         turn_off,
    input  logic [W-1:0] bus_a,
    input  logic [W-1:0] bus_b,
    input  logic [W-1:0] imm,
    input  logic [3:0]   alu_op,
    input  logic         alu_src,
    input  logic [3:0]   rd_buf2,
    input  logic [7:0]   cu_flags2,
    output logic [W-1:0] alu_out,
    output logic [W-1:0] bus_b_buff,
    output logic [3:0]   rd_buf3,
    output logic [7:0]   cu_flags3,
    output logic         zero,
    output logic         stall
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
`ifdef EX_MDIV_EN
    localparam logic [3:0] OP_DIV = 4'd10;
`endif
    localparam int CW = $clog2(MC_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q;
    logic [W-1:0]  a_q, b_q, imm_q;
    logic [3:0]    op_q, rd_q;
    logic          src_q;
    logic [7:0]    flags_q;
    logic [W-1:0]  acc_q, mcand_q, mplier_q;

    logic [W-1:0]  op_b;
    logic [4:0]    shamt;
    logic [W-1:0]  sc_res;
    logic [W-1:0]  mc_res;
    logic          is_div;
    logic          is_mc;

    assign op_b  = src_q ? imm_q : b_q;
    assign shamt = op_b[4:0];

`ifdef EX_MDIV_EN
    // Restoring divider reuses the MUL registers: mcand holds the divisor,
    // mplier shifts the dividend out and the quotient in, acc is the remainder.
    logic [W:0]   r_sh, r_diff;
    logic         div_bit;
    logic [W-1:0] div_rem;

    assign is_div  = (op_q == OP_DIV);
    assign r_sh    = {acc_q, mplier_q[W-1]};
    assign r_diff  = r_sh - {1'b0, mcand_q};
    assign div_bit = ~r_diff[W];
    assign div_rem = div_bit ? r_diff[W-1:0] : r_sh[W-1:0];
    assign mc_res  = is_div ? mplier_q : acc_q;
`else
    assign is_div  = 1'b0;
    assign mc_res  = acc_q;
`endif

    assign is_mc = (op_q == OP_MUL) || is_div;

    always_comb begin
        sc_res = '0;
        case (op_q)
            OP_ADD: sc_res = a_q + op_b;
            OP_SUB: sc_res = a_q - op_b;
            OP_AND: sc_res = a_q & op_b;
            OP_OR:  sc_res = a_q | op_b;
            OP_XOR: sc_res = a_q ^ op_b;
            OP_SLL: sc_res = a_q << shamt;
            OP_SRL: sc_res = a_q >> shamt;
            OP_SRA: sc_res = $unsigned($signed(a_q) >>> shamt);
            OP_SLT: sc_res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(op_b))};
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mc) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (count_q == CW'(MC_CYCLES - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) state_q <= IDLE;
        else if (!turn_off) state_q <= state_d;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            op_q     <= '0;
            src_q    <= 1'b0;
            rd_q     <= '0;
            flags_q  <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (!turn_off) begin
            if (!stall) begin
                a_q     <= bus_a;
                b_q     <= bus_b;
                imm_q   <= imm;
                op_q    <= alu_op;
                src_q   <= alu_src;
                rd_q    <= rd_buf2;
                flags_q <= cu_flags2;
            end
            case (state_q)
                IDLE: begin
                    if (is_mc) begin
                        count_q  <= '0;
                        acc_q    <= '0;
                        mcand_q  <= is_div ? op_b : a_q;
                        mplier_q <= is_div ? a_q : op_b;
                    end
                end
                BUSY: begin
                    count_q <= count_q + CW'(1);
`ifdef EX_MDIV_EN
                    if (is_div) begin
                        acc_q    <= div_rem;
                        mplier_q <= {mplier_q[W-2:0], div_bit};
                    end else
`endif
                    begin
                        // Unsigned shift-add: low W bits of the product land in acc.
                        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_out    = (state_q == DONE) ? mc_res : sc_res;
    assign zero       = (alu_out == '0);
    assign bus_b_buff = b_q;
    assign rd_buf3    = rd_q;
    assign cu_flags3  = stall ? 8'h00 : flags_q;

endmodule
